// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and helpers for the SRAM slave.
//   - HTRANS codes (TRANS_*) and HRESP codes (RESP_*)
//   - state_t: slave FSM state encoding
//   - size_low_mask(): address bits that must be zero for a given HSIZE
//   - lane_mask(): byte-lane enables from HSIZE and the low address bits
package ahb_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Low address bits covered by one transfer of size 2^hsize (max 8 bytes).
  function automatic logic [2:0] size_low_mask(input logic [2:0] hsize);
    logic [2:0] m;
    case (hsize)
      3'd0:    m = 3'b000;
      3'd1:    m = 3'b001;
      3'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  // Byte enables for a transfer of 2^hsize bytes starting at byte offset lo.
  // Little-endian: byte offset N drives data bits [8N+7:8N].
  function automatic logic [7:0] lane_mask(input logic [2:0] hsize,
                                           input logic [2:0] lo);
    logic [7:0] base;
    case (hsize)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lo;
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem: DATA_W x MEM_DEPTH storage array.
// Ports:
//   clk    in   write clock (rising edge)
//   we     in   write strobe
//   be     in   byte enables, one per 8-bit lane
//   idx    in   word index, shared by the write and read ports
//   wdata  in   write data
//   rdata  out  asynchronous read of mem[idx]
// Contents are deliberately not reset.
module ahb_sram_mem #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (we && be[b]) begin
        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with programmable wait states,
// byte/halfword lanes and NONSEQ/SEQ bursts.
// Parameters: DATA_W (32/64), MEM_DEPTH (power of two), WAIT_STATES (0..7).
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,   address phase from the decoder / master
//   HWRITE, HSIZE, HBURST  (HBURST is informational and ignored)
//   HWDATA                 write data, sampled in the data phase
//   HRDATA                 read data, zero outside a completing read
//   HRESP, HREADYout       response and data-phase completion
//   HREADYin               bus-wide ready from the HREADY mux
//   dbg_state              current FSM state (state_t encoding)
// Build option: define AHB_SRAM_ERR_EN to enable out-of-range, misaligned
// and oversize error responses (ERR1/ERR2). Without it HRESP is always
// OKAY, addresses wrap, misaligned addresses are aligned down and oversize
// HSIZE acts as a full word.
//
// Handshake: an address phase is taken at a rising edge when HSEL=1,
// HREADYin=1, HTRANS is NONSEQ/SEQ and this slave is itself ready
// (HREADYout=1); the data phase then completes at the first rising edge
// where HREADYout=1. Nothing is sampled while HREADYin=0.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic [1:0]        HRESP,
  input  logic              HREADYin,
  output logic              HREADYout,
  output logic [2:0]        dbg_state
);

  localparam int         BYTES     = DATA_W / 8;
  localparam int         ADDR_LSB  = $clog2(BYTES);
  localparam int         IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH * BYTES);
  localparam logic [2:0] MAX_SIZE  = 3'(ADDR_LSB);
  localparam logic [2:0] LO_MASK   = 3'(BYTES - 1);

  state_t            state, state_n, acc_state;
  logic [2:0]        cnt;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [2:0]        lo_q, size_q;

  logic              hready_int, can_acc, acc_err;
  logic [2:0]        size_eff, lo_eff;
  logic [7:0]        mask8;
  logic [BYTES-1:0]  be;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Address-phase qualification and normalisation.
  always_comb begin
    size_eff = HSIZE;
    lo_eff   = HADDR[2:0] & LO_MASK;
    acc_err  = 1'b0;
`ifdef AHB_SRAM_ERR_EN
    acc_err  = ({1'b0, HADDR} >= MEM_BYTES)
            || ((HADDR[2:0] & size_low_mask(HSIZE)) != 3'd0)
            || (HSIZE > MAX_SIZE);
`else
    if (HSIZE > MAX_SIZE) size_eff = MAX_SIZE;
    lo_eff   = HADDR[2:0] & LO_MASK & ~size_low_mask(size_eff);
`endif
  end

  // WAIT and ERR1 are the only stall states; accepts are blocked there.
  assign hready_int = (state != ST_WAIT) && (state != ST_ERR1);
  assign can_acc    = HSEL && HREADYin && HTRANS[1] && hready_int;

  always_comb begin
    if (acc_err)               acc_state = ST_ERR1;
    else if (WAIT_STATES == 0) acc_state = ST_DATA;
    else                       acc_state = ST_WAIT;
  end

  always_comb begin
    state_n = ST_IDLE;
    case (state)
      ST_WAIT: state_n = (cnt == 3'd1) ? ST_DATA : ST_WAIT;
`ifdef AHB_SRAM_ERR_EN
      ST_ERR1: state_n = ST_ERR2;
`endif
      // IDLE, DATA and ERR2 all end a cycle with HREADYout=1.
      default: state_n = can_acc ? acc_state : ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= ST_IDLE;
      cnt    <= 3'd0;
      wr_q   <= 1'b0;
      idx_q  <= '0;
      lo_q   <= 3'd0;
      size_q <= 3'd0;
    end else begin
      state <= state_n;
      if (can_acc) begin
        wr_q   <= HWRITE;
        idx_q  <= HADDR[ADDR_LSB +: IDX_W];
        lo_q   <= lo_eff;
        size_q <= size_eff;
      end
      // The counter exits WAIT at 1, so it rests at 0 between transfers.
      if (can_acc && !acc_err && (WAIT_STATES > 0)) begin
        cnt <= 3'(WAIT_STATES);
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  // Writes commit at the edge that ends the DATA cycle, so a read whose
  // data phase starts at that edge sees the new word.
  assign mask8  = lane_mask(size_q, lo_q);
  assign be     = mask8[BYTES-1:0];
  assign mem_we = (state == ST_DATA) && wr_q;

  ahb_sram_mem #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk   (HCLK),
    .we    (mem_we),
    .be    (be),
    .idx   (idx_q),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

  assign HRDATA    = ((state == ST_DATA) && !wr_q) ? mem_rdata : '0;
  assign HREADYout = hready_int;
`ifdef AHB_SRAM_ERR_EN
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
`else
  assign HRESP     = RESP_OKAY;
`endif
  assign dbg_state = state;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HTRANS[0], HADDR, mask8};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with WAIT_STATES=0 and
// one with WAIT_STATES=2 share the bus; each has its own HSEL and loops
// its HREADYout back as HREADYin.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        sel0, sel2;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] rdata0, rdata2;
  logic [1:0]  resp0, resp2;
  logic        ready0, ready2;
  logic [2:0]  st0, st2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] rd;
  logic [1:0]  rsp;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(.DATA_W(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(rdata0), .HRESP(resp0), .HREADYin(ready0),
    .HREADYout(ready0), .dbg_state(st0)
  );

  ahb_sram_slave #(.DATA_W(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel2), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(rdata2), .HRESP(resp2), .HREADYin(ready2),
    .HREADYout(ready2), .dbg_state(st2)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic addr_ph(input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr);
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HADDR  = addr;
  endtask

  // Single non-pipelined transfer with a bounded wait for completion.
  task automatic xfer(input logic dut2, input logic wr, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rdo, output logic [1:0] rspo);
    int n;
    sel0 = !dut2;
    sel2 = dut2;
    addr_ph(TRANS_NONSEQ, wr, size, addr);
    tick();
    HTRANS = TRANS_IDLE;
    HWDATA = wd;
    n = 0;
    @(negedge HCLK);
    while (!(dut2 ? ready2 : ready0) && n < 16) begin
      @(negedge HCLK);
      n++;
    end
    chk("xfer_done", 64'(n < 16), 64'd1);
    rdo  = dut2 ? rdata2 : rdata0;
    rspo = dut2 ? resp2 : resp0;
    tick();
  endtask

  initial begin
    HRESETn = 1'b0;
    sel0 = 1'b0; sel2 = 1'b0;
    HTRANS = TRANS_IDLE; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd2;
    HBURST = 3'd0; HWDATA = '0;

    // Reset values
    @(negedge HCLK);
    chk("rst_ready0", ready0, 1);
    chk("rst_resp0", resp0, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_state0", st0, 0);
    chk("rst_ready2", ready2, 1);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    tick();

    // IDLE and BUSY with HSEL=1: zero-wait OKAY
    sel0 = 1'b1;
    addr_ph(TRANS_IDLE, 1'b0, 3'd2, 32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge HCLK);
      chk("idle_ready", ready0, 1);
      chk("idle_resp", resp0, 0);
    end
    HTRANS = TRANS_BUSY;
    tick();
    @(negedge HCLK);
    chk("busy_ready", ready0, 1);
    chk("busy_state", st0, 0);

    // Write 0xDEADBEEF to 0x10 then pipelined read of 0x10
    tick();
    addr_ph(TRANS_NONSEQ, 1'b1, 3'd2, 32'h10);
    tick();
    HWDATA = 32'hDEADBEEF;
    addr_ph(TRANS_NONSEQ, 1'b0, 3'd2, 32'h10);
    @(negedge HCLK);
    chk("b2b_wr_ready", ready0, 1);
    chk("b2b_wr_rdata", rdata0, 0);
    tick();
    HTRANS = TRANS_IDLE;
    @(negedge HCLK);
    chk("b2b_rd_ready", ready0, 1);
    chk("b2b_rd_data", rdata0, 32'hDEADBEEF);
    tick();
    @(negedge HCLK);
    chk("b2b_after_rdata", rdata0, 0);

    // Byte write 0xAB at 0x13 over a zero word
    xfer(1'b0, 1'b1, 3'd2, 32'h10, 32'h0, rd, rsp);
    xfer(1'b0, 1'b1, 3'd0, 32'h13, 32'hABABABAB, rd, rsp);
    xfer(1'b0, 1'b0, 3'd2, 32'h10, 32'h0, rd, rsp);
    chk("byte_lane3", rd, 32'hAB000000);
    chk("byte_resp", rsp, 0);

    // Halfword write at 0x16 over a zero word
    xfer(1'b0, 1'b1, 3'd2, 32'h14, 32'h0, rd, rsp);
    xfer(1'b0, 1'b1, 3'd1, 32'h16, 32'h56785678, rd, rsp);
    xfer(1'b0, 1'b0, 3'd2, 32'h14, 32'h0, rd, rsp);
    chk("half_upper", rd, 32'h56780000);

    // INCR4 burst 1..4 to 0x20..0x2C with a BUSY cycle
    HBURST = 3'b011;
    sel0 = 1'b1;
    addr_ph(TRANS_NONSEQ, 1'b1, 3'd2, 32'h20);
    tick();
    HWDATA = 32'd1;
    addr_ph(TRANS_SEQ, 1'b1, 3'd2, 32'h24);
    @(negedge HCLK);
    chk("burst_b1_ready", ready0, 1);
    tick();
    HWDATA = 32'd2;
    addr_ph(TRANS_BUSY, 1'b1, 3'd2, 32'h28);
    @(negedge HCLK);
    chk("burst_b2_ready", ready0, 1);
    tick();
    HWDATA = 32'hFFFFFFFF;
    addr_ph(TRANS_SEQ, 1'b1, 3'd2, 32'h28);
    @(negedge HCLK);
    chk("burst_busy_ready", ready0, 1);
    chk("burst_busy_resp", resp0, 0);
    chk("burst_busy_state", st0, 0);
    tick();
    HWDATA = 32'd3;
    addr_ph(TRANS_SEQ, 1'b1, 3'd2, 32'h2C);
    @(negedge HCLK);
    chk("burst_b3_ready", ready0, 1);
    tick();
    HWDATA = 32'd4;
    HTRANS = TRANS_IDLE;
    @(negedge HCLK);
    chk("burst_b4_ready", ready0, 1);
    tick();
    HBURST = 3'd0;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 1'b0, 3'd2, 32'h20 + 32'(4 * i), 32'h0, rd, rsp);
      chk("burst_readback", rd, 64'(i + 1));
    end

    // WAIT_STATES=2: two stall cycles, then OKAY
    xfer(1'b1, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, rd, rsp);
    sel0 = 1'b0; sel2 = 1'b1;
    addr_ph(TRANS_NONSEQ, 1'b0, 3'd2, 32'h40);
    tick();
    HTRANS = TRANS_IDLE;
    @(negedge HCLK);
    chk("ws2_c1_ready", ready2, 0);
    chk("ws2_c1_resp", resp2, 0);
    tick();
    @(negedge HCLK);
    chk("ws2_c2_ready", ready2, 0);
    tick();
    @(negedge HCLK);
    chk("ws2_c3_ready", ready2, 1);
    chk("ws2_c3_resp", resp2, 0);
    chk("ws2_c3_rdata", rdata2, 32'hCAFEF00D);
    tick();
    @(negedge HCLK);
    chk("ws2_idle_state", st2, 0);

`ifdef AHB_SRAM_ERR_EN
    // Out-of-range read: two-cycle ERROR
    sel2 = 1'b0; sel0 = 1'b1;
    addr_ph(TRANS_NONSEQ, 1'b0, 3'd2, 32'h400);
    tick();
    HTRANS = TRANS_IDLE;
    @(negedge HCLK);
    chk("oor_e1_ready", ready0, 0);
    chk("oor_e1_resp", resp0, 1);
    tick();
    @(negedge HCLK);
    chk("oor_e2_ready", ready0, 1);
    chk("oor_e2_resp", resp0, 1);
    chk("oor_e2_rdata", rdata0, 0);
    tick();
    @(negedge HCLK);
    chk("oor_after_resp", resp0, 0);

    // Misaligned word write at 0x02: ERROR, memory unchanged
    xfer(1'b0, 1'b1, 3'd2, 32'h00, 32'h11223344, rd, rsp);
    sel0 = 1'b1;
    addr_ph(TRANS_NONSEQ, 1'b1, 3'd2, 32'h02);
    tick();
    HTRANS = TRANS_IDLE;
    HWDATA = 32'hFFFFFFFF;
    @(negedge HCLK);
    chk("mis_e1_ready", ready0, 0);
    chk("mis_e1_resp", resp0, 1);
    tick();
    @(negedge HCLK);
    chk("mis_e2_ready", ready0, 1);
    chk("mis_e2_resp", resp0, 1);
    tick();
    xfer(1'b0, 1'b0, 3'd2, 32'h00, 32'h0, rd, rsp);
    chk("mis_mem_kept", rd, 32'h11223344);
    chk("mis_readback_resp", rsp, 0);

    // Oversize (8-byte) transfer on a 32-bit slave
    xfer(1'b0, 1'b0, 3'd3, 32'h08, 32'h0, rd, rsp);
    chk("oversize_resp", rsp, 1);
`else
    // Wrap, align-down and oversize-as-word behaviour
    xfer(1'b0, 1'b0, 3'd2, 32'h410, 32'h0, rd, rsp);
    chk("wrap_data", rd, 32'hAB000000);
    chk("wrap_resp", rsp, 0);
    xfer(1'b0, 1'b1, 3'd2, 32'h32, 32'h55AA55AA, rd, rsp);
    chk("align_wr_resp", rsp, 0);
    xfer(1'b0, 1'b0, 3'd2, 32'h30, 32'h0, rd, rsp);
    chk("align_down", rd, 32'h55AA55AA);
    xfer(1'b0, 1'b1, 3'd3, 32'h34, 32'h01020304, rd, rsp);
    xfer(1'b0, 1'b0, 3'd2, 32'h34, 32'h0, rd, rsp);
    chk("oversize_word", rd, 32'h01020304);
`endif

    // Reset during a wait-stated write aborts it
    xfer(1'b1, 1'b1, 3'd2, 32'h48, 32'h11111111, rd, rsp);
    sel0 = 1'b0; sel2 = 1'b1;
    addr_ph(TRANS_NONSEQ, 1'b1, 3'd2, 32'h48);
    tick();
    HTRANS = TRANS_IDLE;
    HWDATA = 32'h22222222;
    HRESETn = 1'b0;
    @(negedge HCLK);
    chk("rst_mid_ready", ready2, 1);
    chk("rst_mid_state", st2, 0);
    tick();
    tick();
    HRESETn = 1'b1;
    tick();
    xfer(1'b1, 1'b0, 3'd2, 32'h48, 32'h0, rd, rsp);
    chk("rst_mid_mem", rd, 32'h11111111);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB-Lite memory slave, the next generation of our single-register `ahb_slave`. It adds a configurable-width, configurable-depth SRAM array, programmable wait states, byte/halfword lanes, and NONSEQ/SEQ burst support. Out-of-range, misaligned and oversize transfers get the standard two-cycle ERROR response. It sits on the AHB interconnect behind the decoder, which supplies HSEL, and the HREADY mux, which supplies HREADYin.

## Interface
- DATA_W, 32: bus and memory word width; 32 or 64.
- MEM_DEPTH, 256: number of DATA_W words; power of two.
- WAIT_STATES, 0: wait cycles inserted in every OKAY data phase; 0–7.
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, 2^HSIZE bytes.
- HBURST  in  3  burst type; informational only, never checked.
- HWDATA  in  DATA_W  write data, sampled in the data phase.
- HRDATA  out  DATA_W  read data, valid while HREADYout=1 in a read data phase; 0 otherwise.
- HRESP  out  2  00 OKAY, 01 ERROR.
- HREADYin  in  1  bus-wide ready; an address phase is accepted only when this is 1.
- HREADYout  out  1  slave ready / data-phase completion.

## Operation
- Accept: at a rising edge with HSEL=1, HREADYin=1 and HTRANS[1]=1, register HADDR, HWRITE and HSIZE, then enter the data phase.
- IDLE and BUSY, or HSEL=0: no access. The next cycle has HREADYout=1 and HRESP=00 with zero wait.
- Error check runs at accept. Any one of the following is an error:
  - byte address ≥ MEM_DEPTH·DATA_W/8;
  - HADDR not aligned to 2^HSIZE;
  - 2^HSIZE > DATA_W/8.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE → DATA on a valid accept with WAIT_STATES=0. IDLE → WAIT on a valid accept with WAIT_STATES>0. IDLE → ERR1 on an erroring accept.
  - WAIT: HREADYout=0, HRESP=00. A down-counter loaded with WAIT_STATES moves the FSM to DATA when it reaches 1.
  - DATA: HREADYout=1, HRESP=00. A write commits at this edge, byte-enabled by registered HSIZE/HADDR lanes. If a new accept occurs at this edge, branch as from IDLE; otherwise go to IDLE.
  - ERR1: HREADYout=0, HRESP=01, always → ERR2.
  - ERR2: HREADYout=1, HRESP=01, no memory write. A new accept is legal here and branches as from IDLE.
- Reads: HRDATA is the full word at the registered word index. Masters pick the lanes they need.
- Memory contents are not reset.

## Timing
- Reset values: HREADYout=1, HRESP=00, HRDATA=0, FSM=IDLE, counter=0. Reset asserted mid-transfer aborts it, and any uncommitted write is lost.
- Latency from the accept edge to completion: 1 + WAIT_STATES cycles for OKAY, exactly 2 cycles for ERROR.
- Write followed by read to the same address in pipelined back-to-back cycles: the read returns the new data. The write commits at the edge where the read's data phase begins.
- Inputs sampled while HREADYin=0 are ignored.

## Configuration
- AHB_SRAM_ERR_EN defined: error checking and states ERR1/ERR2 are present, as described above.
- AHB_SRAM_ERR_EN undefined:
  - HRESP is tied to 00 and the ERR states are removed;
  - addresses wrap modulo the memory size;
  - misaligned addresses are aligned down to 2^HSIZE;
  - oversize HSIZE is treated as a full word.

## Structure
- Package ahb_pkg holds:
  - HTRANS codes: TRANS_IDLE, TRANS_BUSY, TRANS_NONSEQ, TRANS_SEQ;
  - HRESP codes: RESP_OKAY, RESP_ERROR;
  - the FSM state enum;
  - a function returning the byte-lane mask from HSIZE and the low address bits.
- One sub-module, ahb_sram_mem: a DATA_W × MEM_DEPTH array with byte-enabled write and an asynchronous read port.

## Test plan
- Reset, then HTRANS=00 with HSEL=1 → HREADYout=1 and HRESP=00 on every cycle.
- WAIT_STATES=0: NONSEQ write of 0xDEADBEEF to 0x10, then back-to-back read of 0x10 → HRDATA=0xDEADBEEF in the read's data phase, and HREADYout never drops.
- WAIT_STATES=2: word read → HREADYout is 0 for exactly 2 cycles, then 1 with HRESP=00.
- HSIZE=0 byte write of 0xAB to 0x13 over a word containing 0x00000000 → a read of 0x10 returns 0xAB000000.
- With AHB_SRAM_ERR_EN:
  - a read of address MEM_DEPTH·4 → (HREADYout=0, HRESP=01), then (1, 01);
  - HSIZE=2 at 0x02 → the same two-cycle ERROR, and memory is unchanged.
- INCR4 SEQ burst writing 1–4 to 0x20–0x2C with a BUSY cycle inserted → the BUSY cycle gives OKAY with zero wait, and read-back returns 1, 2, 3, 4.
